// File: rtl/stack_lifo_param.sv
// Parametrised synchronous LIFO stack with replace-top (push+pop), occupancy count,
// almost-full threshold, sticky overflow/underflow flags, flush and a read-valid strobe.
module stack_lifo_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6,
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    sp_q, sp_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             is_empty, is_full;
  logic [AW-1:0]    top_idx, wr_idx;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == CW'(DEPTH));

  // top_idx is only meaningful when the stack is not empty.
  assign top_idx  = AW'(sp_q - CW'(1));
  assign wr_idx   = AW'(sp_q);

  always_comb begin
    sp_d      = sp_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    mem_we    = 1'b0;
    mem_waddr = wr_idx;

    if (flush) begin
      sp_d = '0;
    end else begin
      // Clear first so that an error raised in the same cycle wins.
      if (clr_err) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end

      case ({push, pop})
        2'b10: begin
          if (!is_full) begin
            mem_we    = 1'b1;
            mem_waddr = wr_idx;
            sp_d      = sp_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        2'b01: begin
          if (!is_empty) begin
            dout_d  = mem[top_idx];
            valid_d = 1'b1;
            sp_d    = sp_q - CW'(1);
          end else begin
            unf_d = 1'b1;
          end
        end
        2'b11: begin
          if (!is_empty) begin
            dout_d    = mem[top_idx];
            valid_d   = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = top_idx;
          end else begin
            // Empty bypass: the pushed word goes straight to the consumer.
            dout_d  = data_in;
            valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[mem_waddr] <= data_in;
    end
  end

  assign data_out    = dout_q;
  assign data_valid  = valid_q;
  assign count       = sp_q;
  assign empty       = is_empty;
  assign full        = is_full;
  assign almost_full = (sp_q >= CW'(AF_LEVEL));
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_stack_lifo_param.sv
// Bench for stack_lifo_param: two instances (8x4, AF 6 and 5x12, AF 5) driven in lockstep,
// each compared every cycle against an array-based LIFO model.
module tb_stack_lifo_param;

  logic        clk = 1'b0;
  logic        reset, flush, push, pop, clr_err;
  logic [11:0] din;

  logic [3:0]  a_dout;
  logic [3:0]  a_count;
  logic        a_valid, a_empty, a_full, a_af, a_ovf, a_unf;
  logic [11:0] b_dout;
  logic [2:0]  b_count;
  logic        b_valid, b_empty, b_full, b_af, b_ovf, b_unf;

  int tests  = 0;
  int failed = 0;

  // Model state, index 0 = instance A, 1 = instance B.
  logic [11:0] stk    [2][8];
  int          n_m    [2];
  logic [11:0] dout_m [2];
  logic        valid_m[2];
  logic        ovf_m  [2];
  logic        unf_m  [2];

  always #5 clk = ~clk;

  stack_lifo_param #(.WIDTH(4), .DEPTH(8), .AF_LEVEL(6)) u_a (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .pop        (pop),
    .data_in    (din[3:0]),
    .clr_err    (clr_err),
    .data_out   (a_dout),
    .data_valid (a_valid),
    .count      (a_count),
    .empty      (a_empty),
    .full       (a_full),
    .almost_full(a_af),
    .overflow   (a_ovf),
    .underflow  (a_unf)
  );

  stack_lifo_param #(.WIDTH(12), .DEPTH(5), .AF_LEVEL(5)) u_b (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .pop        (pop),
    .data_in    (din),
    .clr_err    (clr_err),
    .data_out   (b_dout),
    .data_valid (b_valid),
    .count      (b_count),
    .empty      (b_empty),
    .full       (b_full),
    .almost_full(b_af),
    .overflow   (b_ovf),
    .underflow  (b_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural LIFO update for one instance, using the pre-edge input values.
  task automatic model(input int i);
    int          d;
    int          af;
    logic [11:0] w;
    d  = (i == 0) ? 8 : 5;
    af = (i == 0) ? 6 : 5;
    w  = (i == 0) ? (din & 12'h00f) : din;
    if (reset) begin
      n_m[i] = 0; dout_m[i] = '0; valid_m[i] = 1'b0; ovf_m[i] = 1'b0; unf_m[i] = 1'b0;
    end else if (flush) begin
      n_m[i] = 0; valid_m[i] = 1'b0;
    end else begin
      valid_m[i] = 1'b0;
      if (clr_err) begin
        ovf_m[i] = 1'b0; unf_m[i] = 1'b0;
      end
      if (push && pop) begin
        valid_m[i] = 1'b1;
        if (n_m[i] > 0) begin
          dout_m[i] = stk[i][n_m[i]-1];
          stk[i][n_m[i]-1] = w;
        end else begin
          dout_m[i] = w;
        end
      end else if (push) begin
        if (n_m[i] < d) begin
          stk[i][n_m[i]] = w;
          n_m[i]++;
        end else begin
          ovf_m[i] = 1'b1;
        end
      end else if (pop) begin
        if (n_m[i] > 0) begin
          n_m[i]--;
          dout_m[i] = stk[i][n_m[i]];
          valid_m[i] = 1'b1;
        end else begin
          unf_m[i] = 1'b1;
        end
      end
    end
    if (af < 0) $fatal(1, "bad af");
  endtask

  task automatic check_all();
    chk("a_count", 32'(a_count), 32'(n_m[0]));
    chk("a_empty", 32'(a_empty), 32'(n_m[0] == 0));
    chk("a_full",  32'(a_full),  32'(n_m[0] == 8));
    chk("a_af",    32'(a_af),    32'(n_m[0] >= 6));
    chk("a_dout",  32'(a_dout),  32'(dout_m[0]));
    chk("a_valid", 32'(a_valid), 32'(valid_m[0]));
    chk("a_ovf",   32'(a_ovf),   32'(ovf_m[0]));
    chk("a_unf",   32'(a_unf),   32'(unf_m[0]));
    chk("b_count", 32'(b_count), 32'(n_m[1]));
    chk("b_empty", 32'(b_empty), 32'(n_m[1] == 0));
    chk("b_full",  32'(b_full),  32'(n_m[1] == 5));
    chk("b_af",    32'(b_af),    32'(n_m[1] >= 5));
    chk("b_dout",  32'(b_dout),  32'(dout_m[1]));
    chk("b_valid", 32'(b_valid), 32'(valid_m[1]));
    chk("b_ovf",   32'(b_ovf),   32'(ovf_m[1]));
    chk("b_unf",   32'(b_unf),   32'(unf_m[1]));
  endtask

  task automatic step(input logic p, input logic po, input logic [11:0] d,
                      input logic c, input logic f, input logic r);
    push = p; pop = po; din = d; clr_err = c; flush = f; reset = r;
    @(posedge clk);
    model(0);
    model(1);
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = '0;
    for (int i = 0; i < 2; i++) begin
      n_m[i] = 0; dout_m[i] = '0; valid_m[i] = 1'b0; ovf_m[i] = 1'b0; unf_m[i] = 1'b0;
    end

    // 1: reset, fill, drain
    step(0, 0, 0, 0, 0, 1);
    chk("rst_a_empty", 32'(a_empty), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      step(1, 0, 12'(k), 0, 0, 0);
      chk("fill_a_af", 32'(a_af), 32'(k >= 6));
    end
    chk("fill_a_count", 32'(a_count), 32'd8);
    chk("fill_b_count", 32'(b_count), 32'd5);

    // 2: overflow and clr_err interaction
    step(1, 0, 12'd9, 0, 0, 0);
    chk("ovf_a", 32'(a_ovf), 32'd1);
    step(0, 0, 0, 1, 0, 0);
    chk("clr_a_ovf", 32'(a_ovf), 32'd0);
    step(1, 0, 12'd9, 1, 0, 0);
    chk("set_wins_a", 32'(a_ovf), 32'd1);

    for (int k = 8; k >= 1; k--) begin
      step(0, 1, 0, 0, 0, 0);
      chk("drain_a_dout", 32'(a_dout), 32'(k));
    end
    chk("drain_a_empty", 32'(a_empty), 32'd1);

    // 3: underflow, empty bypass
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("unf_a", 32'(a_unf), 32'd1);
    step(1, 1, 12'h0a5, 0, 0, 0);
    chk("bypass_a_dout", 32'(a_dout), 32'h5);

    // 4: replace-top, including at full
    step(1, 0, 12'd3, 1, 0, 0);
    step(1, 0, 12'd5, 0, 0, 0);
    step(1, 1, 12'd7, 0, 0, 0);
    chk("swap_a_dout", 32'(a_dout), 32'd5);
    step(0, 1, 0, 0, 0, 0);
    chk("swap_pop_a", 32'(a_dout), 32'd7);
    for (int k = 0; k < 7; k++) step(1, 0, 12'(k + 2), 0, 0, 0);
    step(1, 1, 12'hc, 0, 0, 0);
    chk("swap_full_cnt", 32'(a_count), 32'd8);

    // 5: flush, then reset with push held
    step(0, 0, 0, 1, 1, 0);
    for (int k = 0; k < 4; k++) step(1, 0, 12'(k + 1), 0, 0, 0);
    step(1, 0, 12'hf, 0, 0, 1);
    chk("rst_a_dout", 32'(a_dout), 32'd0);

    // Randomised traffic, push-biased then pop-biased.
    for (int k = 0; k < 400; k++) begin
      int pb;
      pb = (k % 100 < 50) ? 65 : 35;
      step(($urandom_range(0, 99) < pb), ($urandom_range(0, 99) < 100 - pb),
           12'($urandom), ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
